// File: rtl/mips_mem_responder_pkg.sv
// Shared types and address-decode helper for the mips memory responder.
package mips_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_FFFC;

  // True when addr is word-aligned and falls inside a memory of depth words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return (addr[1:0] == 2'b00) && (addr[31:2] < 30'(depth));
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Boot-stream and core memory bus between the mips core/bench and the responder.
interface mips_mem_responder_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        cpu_rst;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [31:0] ALUOut;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [15:0] mmio_value;
  logic        mem_err;
  logic [31:0] run_cycles;

  modport master (
    output load_valid, load_data, load_last, PC, ALUOut, WriteData, MemWrite,
    input  load_ready, cpu_rst, Instr, ReadData, mmio_value, mem_err, run_cycles
  );

  modport slave (
    input  load_valid, load_data, load_last, PC, ALUOut, WriteData, MemWrite,
    output load_ready, cpu_rst, Instr, ReadData, mmio_value, mem_err, run_cycles
  );
endinterface

// File: rtl/mips_mem_responder_ram.sv
// Single write port, single asynchronous read port RAM; contents are never reset.
module mips_ram_1w1r #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-during-write returns the old word; the write lands on the edge.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the single-cycle mips core: boot loader FSM, imem/dmem, MMIO and status.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] MMIO_ADDR  = MMIO_ADDR_DEFAULT
) (
  input logic                 CLK,
  input logic                 rst,
  mips_mem_responder_if.slave bus
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [IAW-1:0] LAST_PTR = IAW'(IMEM_DEPTH - 1);

  state_t         state_q;
  logic [IAW-1:0] load_ptr_q;
  logic           cpu_rst_q;
  logic           mem_err_q;
  logic [15:0]    mmio_q;
  logic [31:0]    run_cycles_q;
  logic [31:0]    run_cycles_d;

  logic [31:0] imem_rdata;
  logic [31:0] dmem_rdata;
  logic        in_run;
  logic        load_fire;
  logic        fetch_ok;
  logic        data_ok;
  logic        is_mmio;
  logic        dmem_we;
  logic        store_bad;

  assign in_run    = (state_q == RUN);
  assign load_fire = (state_q == LOAD) && bus.load_valid;
  assign fetch_ok  = addr_in_range(bus.PC, IMEM_DEPTH);
  assign data_ok   = addr_in_range(bus.ALUOut, DMEM_DEPTH);
  assign is_mmio   = (bus.ALUOut == MMIO_ADDR);
  assign dmem_we   = in_run && bus.MemWrite && data_ok && !is_mmio;
  assign store_bad = bus.MemWrite && !is_mmio && !data_ok;

  assign run_cycles_d = (run_cycles_q != 32'hFFFF_FFFF) ? run_cycles_q + 32'd1 : run_cycles_q;

  mips_ram_1w1r #(.DEPTH(IMEM_DEPTH), .WIDTH(32)) u_imem (
    .clk     (CLK),
    .we_i    (load_fire),
    .waddr_i (load_ptr_q),
    .wdata_i (bus.load_data),
    .raddr_i (bus.PC[IAW+1:2]),
    .rdata_o (imem_rdata)
  );

  mips_ram_1w1r #(.DEPTH(DMEM_DEPTH), .WIDTH(32)) u_dmem (
    .clk     (CLK),
    .we_i    (dmem_we),
    .waddr_i (bus.ALUOut[DAW+1:2]),
    .wdata_i (bus.WriteData),
    .raddr_i (bus.ALUOut[DAW+1:2]),
    .rdata_o (dmem_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      cpu_rst_q    <= 1'b0;
      mmio_q       <= 16'h0000;
      mem_err_q    <= 1'b0;
      run_cycles_q <= 32'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_fire) begin
            load_ptr_q <= load_ptr_q + IAW'(1);
            if (bus.load_last || (load_ptr_q == LAST_PTR)) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // Core reset is released one edge after the LOAD->RUN transition.
          cpu_rst_q    <= 1'b1;
          run_cycles_q <= run_cycles_d;
          if (bus.MemWrite && is_mmio) begin
            mmio_q <= bus.WriteData[15:0];
          end
          if (!fetch_ok || store_bad) begin
            mem_err_q <= 1'b1;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.load_ready = (state_q == LOAD);
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.Instr      = fetch_ok ? imem_rdata : 32'h0000_0000;
  assign bus.ReadData   = is_mmio ? {16'h0000, mmio_q}
                        : (data_ok ? dmem_rdata : 32'h0000_0000);
  assign bus.mmio_value = mmio_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench: stimulus queues expected values, a negedge monitor pops and compares them.
module tb_mips_mem_responder;

  localparam int S_INSTR  = 0;
  localparam int S_RDATA  = 1;
  localparam int S_MMIO   = 2;
  localparam int S_ERR    = 3;
  localparam int S_CPURST = 4;
  localparam int S_READY  = 5;
  localparam int S_CYC    = 6;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } chk_t;

  logic clk;
  logic rst;
  chk_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic exp_run = 1'b0;
  int   run_edges = 0;

  mips_mem_responder_if bus ();

  mips_mem_responder #(
    .IMEM_DEPTH (64),
    .DMEM_DEPTH (64),
    .MMIO_ADDR  (32'h0000_FFFC)
  ) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] act(input int sig);
    case (sig)
      S_INSTR:  return bus.Instr;
      S_RDATA:  return bus.ReadData;
      S_MMIO:   return {16'h0000, bus.mmio_value};
      S_ERR:    return {31'd0, bus.mem_err};
      S_CPURST: return {31'd0, bus.cpu_rst};
      S_READY:  return {31'd0, bus.load_ready};
      default:  return bus.run_cycles;
    endcase
  endfunction

  // Monitor: every negedge, compare everything queued since the last edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = sb.pop_front();
      a = act(c.sig);
      n_vec++;
      if (a !== c.exp) begin
        n_miss++;
        $display("FAIL %s: got %08h expected %08h", c.name, a, c.exp);
      end else begin
        $display("ok   %s = %08h", c.name, a);
      end
    end
  end

  task automatic chk(input string name, input int sig, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (exp_run) run_edges++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    exp_run   = 1'b0;
    run_edges = 0;
  endtask

  initial begin
    rst = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 32'd0;
    bus.load_last  = 1'b0;
    bus.PC         = 32'd0;
    bus.ALUOut     = 32'd0;
    bus.WriteData  = 32'd0;
    bus.MemWrite   = 1'b0;

    // Reset state
    step();
    do_reset();
    chk("rst_ready", S_READY, 32'd1);
    chk("rst_cpurst", S_CPURST, 32'd0);
    chk("rst_err", S_ERR, 32'd0);
    chk("rst_mmio", S_MMIO, 32'd0);
    chk("rst_cyc", S_CYC, 32'd0);
    rst = 1'b1;

    // 1: boot three beats
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h2008_0005;
    chk("boot_ready", S_READY, 32'd1);
    step();
    bus.load_data = 32'h2009_000A;
    step();
    bus.load_data = 32'hAC09_0004;
    bus.load_last = 1'b1;
    step();
    exp_run = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("boot_ready_drop", S_READY, 32'd0);
    chk("boot_cpurst_held", S_CPURST, 32'd0);
    step();
    chk("boot_cpurst_rel", S_CPURST, 32'd1);
    chk("boot_cyc", S_CYC, 32'(run_edges));
    bus.PC = 32'd8;
    chk("fetch_pc8", S_INSTR, 32'hAC09_0004);
    step();
    bus.PC = 32'd4;
    chk("fetch_pc4", S_INSTR, 32'h2009_000A);
    step();
    bus.PC = 32'd0;
    chk("fetch_pc0", S_INSTR, 32'h2008_0005);
    step();

    // 2: store/load with read-during-write
    bus.ALUOut    = 32'd4;
    bus.MemWrite  = 1'b1;
    bus.WriteData = 32'd0;
    step();
    bus.WriteData = 32'hDEAD_BEEF;
    chk("st_same_cycle_old", S_RDATA, 32'd0);
    step();
    bus.MemWrite = 1'b0;
    chk("ld_after_store", S_RDATA, 32'hDEAD_BEEF);
    step();

    // 3: MMIO store
    bus.ALUOut    = 32'h0000_FFFC;
    bus.MemWrite  = 1'b1;
    bus.WriteData = 32'h1234_ABCD;
    chk("mmio_old_rd", S_RDATA, 32'd0);
    chk("mmio_old_val", S_MMIO, 32'd0);
    step();
    bus.MemWrite = 1'b0;
    chk("mmio_val", S_MMIO, 32'h0000_ABCD);
    chk("mmio_rd", S_RDATA, 32'h0000_ABCD);
    step();
    bus.ALUOut = 32'd4;
    chk("mmio_dmem_untouched", S_RDATA, 32'hDEAD_BEEF);
    chk("no_err_yet", S_ERR, 32'd0);
    step();

    // 4: errors
    bus.PC = 32'h0000_0102;
    chk("fetch_oor_nop", S_INSTR, 32'd0);
    chk("err_registered", S_ERR, 32'd0);
    step();
    bus.PC = 32'd0;
    chk("err_set_fetch", S_ERR, 32'd1);
    step();
    bus.PC = 32'd2;
    chk("fetch_misalign_nop", S_INSTR, 32'd0);
    step();
    bus.PC        = 32'd0;
    bus.ALUOut    = 32'd0;
    bus.MemWrite  = 1'b1;
    bus.WriteData = 32'h1111_1111;
    step();
    bus.ALUOut    = 32'h0000_0400;
    bus.WriteData = 32'h5555_5555;
    chk("st_oor_rd_zero", S_RDATA, 32'd0);
    step();
    bus.MemWrite = 1'b0;
    bus.ALUOut   = 32'd0;
    chk("st_oor_dropped", S_RDATA, 32'h1111_1111);
    chk("err_sticky", S_ERR, 32'd1);
    step();
    bus.ALUOut = 32'd6;
    chk("ld_misalign_zero", S_RDATA, 32'd0);
    chk("run_cyc_count", S_CYC, 32'(run_edges));
    step();

    // 6: mid-run reset
    bus.ALUOut = 32'd0;
    bus.PC     = 32'd8;
    do_reset();
    chk("mr_cpurst", S_CPURST, 32'd0);
    chk("mr_cyc", S_CYC, 32'd0);
    chk("mr_ready", S_READY, 32'd1);
    chk("mr_mmio", S_MMIO, 32'd0);
    chk("mr_err", S_ERR, 32'd0);
    chk("mr_imem_persist", S_INSTR, 32'hAC09_0004);
    rst = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hAAAA_0001;
    bus.load_last  = 1'b1;
    step();
    exp_run = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.PC = 32'd0;
    chk("mr_overwrite_w0", S_INSTR, 32'hAAAA_0001);
    step();
    bus.PC = 32'd4;
    chk("mr_keep_w1", S_INSTR, 32'h2009_000A);
    step();
    bus.PC = 32'd8;
    chk("mr_keep_w2", S_INSTR, 32'hAC09_0004);
    chk("mr_err_clear", S_ERR, 32'd0);
    step();

    // 5: full 64-word load without last
    bus.PC = 32'd0;
    do_reset();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 32'h1000_0000 + 32'(i);
      bus.load_last  = 1'b0;
      if (i == 0 || i == 63) chk("full_ready", S_READY, 32'd1);
      step();
    end
    exp_run = 1'b1;
    bus.load_data = 32'hFFFF_FFFF;
    chk("full_ready_drop", S_READY, 32'd0);
    chk("full_cpurst_held", S_CPURST, 32'd0);
    step();
    bus.load_valid = 1'b0;
    chk("full_cpurst_rel", S_CPURST, 32'd1);
    chk("full_beat65_rejected", S_INSTR, 32'h1000_0000);
    step();
    bus.PC = 32'd252;
    chk("full_last_word", S_INSTR, 32'h1000_003F);
    step();
    bus.PC = 32'd256;
    chk("fetch_boundary_nop", S_INSTR, 32'd0);
    chk("boundary_err_pending", S_ERR, 32'd0);
    step();
    bus.PC = 32'd0;
    chk("boundary_err_set", S_ERR, 32'd1);
    chk("full_cyc", S_CYC, 32'(run_edges));
    step();

    // Drain: the monitor should have consumed everything by now.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
